// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side drain stage for fifo_top (rd_clk domain).
// Pops the FIFO, captures data_out one cycle later into a 2-entry buffer and
// presents the words on a valid/ready stream without ever popping while empty.
// Optional statistics counters are enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [15:0]           stat_words,
  output logic [15:0]           stat_stalls
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic [1:0]            occ;
  logic                  drain;
  logic                  arrival;

  // Occupancy state register
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next-state: flush empties the buffer, otherwise count arrivals/drains
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (arrival) state_d = ONE;
        ONE: begin
          if (arrival && !drain)      state_d = TWO;
          else if (drain && !arrival) state_d = EMPTY;
        end
        TWO:     if (drain) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs and handshake terms; pop only when the word is guaranteed a slot
  always_comb begin
    case (state_q)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    m_valid = (state_q != EMPTY);
    m_data  = buf0_q;
    drain   = m_valid && m_ready;
    arrival = inflight_q && !flush;
    // occ + inflight - drain < 2, rearranged to stay unsigned
    fifo_pop = rd_rst && !fifo_empty && !flush &&
               (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, drain}));
  end

  // Buffer steering: drain shifts buf1 forward, arrival fills the first free slot
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = fifo_pop;
    if (drain) begin
      buf0_d = buf1_q;
    end
    if (arrival) begin
      if ((occ == 2'd0) || ((occ == 2'd1) && drain)) begin
        buf0_d = fifo_data_out;
      end else begin
        buf1_d = fifo_data_out;
      end
    end
  end

  // Datapath and in-flight registers
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [15:0] stat_words_q, stat_words_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;

  // Saturating delivery and stall counters; only reset clears them
  always_comb begin
    stat_words_d  = stat_words_q;
    stat_stalls_d = stat_stalls_q;
    if (drain && (stat_words_q != '1)) begin
      stat_words_d = stat_words_q + 16'd1;
    end
    if (m_valid && !m_ready && (stat_stalls_q != '1)) begin
      stat_stalls_d = stat_stalls_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_words_q  <= stat_words_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_words  = stat_words_q;
  assign stat_stalls = stat_stalls_q;
`else
  assign stat_words  = '0;
  assign stat_stalls = '0;
`endif

  // A full buffer must never receive a word without simultaneously draining one
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst)
    !((state_q == TWO) && arrival && !drain));

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: a queue-based FIFO feeds the DUT and a
// queue-based model of buffered words predicts the stream every cycle.
module tb_fifo_rd_drain;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        fifo_empty;
  logic [7:0]  fifo_data_out;
  logic        fifo_pop;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        flush;
  logic [15:0] stat_words;
  logic [15:0] stat_stalls;

  fifo_rd_drain #(.DATA_WIDTH(8)) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_pop      (fifo_pop),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .flush         (flush),
    .stat_words    (stat_words),
    .stat_stalls   (stat_stalls)
  );

  always #5 rd_clk = ~rd_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: words written to feed_q become visible after the next edge
  logic [7:0] feed_q[$];
  logic [7:0] fq[$];
  logic [7:0] fw;

  always @(posedge rd_clk) begin
    if (!rd_rst) begin
      fq.delete();
      feed_q.delete();
      fifo_data_out <= '0;
      fifo_empty    <= 1'b1;
    end else begin
      if (fifo_pop && (fq.size() > 0)) begin
        fw = fq.pop_front();
        fifo_data_out <= fw;
      end
      while (feed_q.size() > 0) fq.push_back(feed_q.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Stream model: bq holds words that have arrived and not yet been accepted
  logic [7:0] bq[$];
  logic [7:0] in_log[$];
  logic [7:0] out_q[$];
  bit         infl_v = 0;
  logic [7:0] infl_w;
  int         exp_words = 0, exp_stalls = 0;
  int         cyc = 0, valid_n = 0, first_v = -1, last_v = -1;
  int         pops_n = 0, drains_n = 0, max_out = 0, underflow_n = 0;

  always @(negedge rd_clk) begin
    bit drain_m, pop_exp;
    int held;
    cyc++;
    if (!rd_rst) begin
      bq.delete();
      infl_v     = 0;
      exp_words  = 0;
      exp_stalls = 0;
    end else begin
      drain_m = (bq.size() > 0) && m_ready;
      chk("m_valid", m_valid, (bq.size() > 0));
      if (bq.size() > 0) chk("m_data", m_data, bq[0]);
      held    = bq.size() + (infl_v ? 1 : 0) - (drain_m ? 1 : 0);
      pop_exp = !fifo_empty && !flush && (held < 2);
      chk("fifo_pop", fifo_pop, pop_exp);
`ifdef FIFO_RD_STATS_EN
      chk("stat_words", stat_words, exp_words);
      chk("stat_stalls", stat_stalls, exp_stalls);
`else
      chk("stat_words", stat_words, 32'd0);
      chk("stat_stalls", stat_stalls, 32'd0);
`endif
      if (fifo_pop && fifo_empty) underflow_n++;
      if (m_valid) begin
        valid_n++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (fifo_pop) pops_n++;
      if (m_valid && m_ready) drains_n++;
      if (pops_n - drains_n > max_out) max_out = pops_n - drains_n;
      // advance the model across the coming edge
      if (drain_m) begin
        out_q.push_back(bq[0]);
        bq.pop_front();
        if (exp_words < 65535) exp_words++;
      end
      if ((bq.size() > 0 || drain_m) && !m_ready && !drain_m) begin
        if (exp_stalls < 65535) exp_stalls++;
      end
      if (flush) bq.delete();
      else if (infl_v) bq.push_back(infl_w);
      infl_v = pop_exp && (fq.size() > 0);
      if (infl_v) infl_w = fq[0];
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    feed_q.push_back(w);
    in_log.push_back(w);
  endtask

  task automatic clear_logs();
    in_log.delete();
    out_q.delete();
    valid_n = 0; first_v = -1; last_v = -1;
    pops_n = 0; drains_n = 0; max_out = 0; underflow_n = 0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    @(posedge rd_clk);
    #3;
    rd_rst = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_fifo_pop", fifo_pop, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_stat_words", stat_words, 16'h0000);
    chk("rst_stat_stalls", stat_stalls, 16'h0000);
    @(posedge rd_clk);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b1;
  endtask

  task automatic check_in_order(input string name);
    int mism = 0;
    chk({name, "_count"}, out_q.size(), in_log.size());
    for (int i = 0; i < out_q.size() && i < in_log.size(); i++)
      if (out_q[i] !== in_log[i]) mism++;
    chk({name, "_order"}, mism, 0);
  endtask

  logic [7:0] t4_exp[4];
  bit         found;

  initial begin
    rd_rst  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("init_m_valid", m_valid, 1'b0);
    chk("init_m_data", m_data, 8'h00);
    tick();
    tick();
    rd_rst = 1'b1;
    tick();

    // 1: single word
    do_reset();
    clear_logs();
    m_ready = 1'b1;
    push(8'hA5);
    repeat (8) tick();
    chk("t1_pops", pops_n, 1);
    chk("t1_valid_cycles", valid_n, 1);
    chk("t1_words", out_q.size(), 1);
    if (out_q.size() > 0) chk("t1_data", out_q[0], 8'hA5);
`ifdef FIFO_RD_STATS_EN
    chk("t1_stat_words", stat_words, 16'd1);
`else
    chk("t1_stat_words", stat_words, 16'd0);
`endif

    // 2: streaming at full rate
    clear_logs();
    for (int i = 0; i < 16; i++) push(8'(i));
    repeat (25) tick();
    chk("t2_valid_cycles", valid_n, 16);
    chk("t2_contiguous", last_v - first_v + 1, 16);
    chk("t2_underflow", underflow_n, 0);
    check_in_order("t2");

    // 3: back-pressure during cycles 3..12 after the push
    do_reset();
    clear_logs();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    for (int c = 0; c < 40; c++) begin
      if (c == 3)  m_ready = 1'b0;
      if (c == 13) m_ready = 1'b1;
      tick();
    end
    chk("t3_max_outstanding_le2", (max_out <= 2), 1'b1);
    check_in_order("t3");
`ifdef FIFO_RD_STATS_EN
    chk("t3_stat_stalls", stat_stalls, 16'd10);
    chk("t3_stat_words", stat_words, 16'd16);
`else
    chk("t3_stat_stalls", stat_stalls, 16'd0);
`endif

    // 4: flush with a full buffer, then flush with a word in flight
    do_reset();
    clear_logs();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    repeat (6) tick();
    chk("t4_full_head", m_data, 8'h40);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_after_flush1_valid", m_valid, 1'b0);
    m_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (m_valid && (m_data == 8'h44)) found = 1;
    end
    chk("t4_wait_head44", found, 1'b1);
    m_ready = 1'b0;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    chk("t4_after_flush2_valid", m_valid, 1'b0);
    m_ready = 1'b1;
    repeat (15) tick();
    t4_exp = '{8'h42, 8'h43, 8'h46, 8'h47};
    chk("t4_count", out_q.size(), 4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) chk("t4_data", out_q[i], t4_exp[i]);

    // 5: asynchronous reset mid-stream, then restart from empty
    clear_logs();
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
    repeat (5) tick();
    chk("t5_streaming_before_reset", m_valid, 1'b1);
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) push(8'(8'h90 + i));
    repeat (12) tick();
    check_in_order("t5");

    // 6: random back-pressure with a FIFO that keeps running dry
    clear_logs();
    for (int c = 0; c < 1000; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) push(8'($urandom_range(0, 255)));
      tick();
    end
    m_ready = 1'b1;
    repeat (40) tick();
    chk("t6_underflow", underflow_n, 0);
    check_in_order("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain stage sitting directly downstream of `fifo_top`, in the `rd_clk` domain. It issues `pop` to the FIFO read port, captures `data_out` one cycle after each pop, and presents the words on a valid/ready stream. A 2-entry output buffer keeps throughput at one word per cycle under back-pressure and guarantees the FIFO is never popped while empty.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of FIFO words and stream data.

Ports:
- `rd_clk`, in, 1, read-domain clock; everything is sampled on its rising edge.
- `rd_rst`, in, 1, asynchronous active-low reset.
- `fifo_empty`, in, 1, FIFO empty flag.
- `fifo_data_out`, in, DATA_WIDTH, FIFO read data; valid the cycle after `fifo_pop`.
- `fifo_pop`, out, 1, pop request to the FIFO.
- `m_valid`, out, 1, stream word available.
- `m_ready`, in, 1, downstream accepts the word.
- `m_data`, out, DATA_WIDTH, stream word.
- `flush`, in, 1, synchronous discard of all buffered and in-flight words.
- `stat_words`, out, 16, words delivered (FIFO_RD_STATS_EN only).
- `stat_stalls`, out, 16, stall cycles (FIFO_RD_STATS_EN only).

## Operation
- Internal state:
  - `inflight` (1 bit): a pop was issued last cycle.
  - Occupancy FSM with states EMPTY, ONE, TWO.
  - Two buffer registers `buf0` (head) and `buf1`.
- Transfer: `drain = m_valid && m_ready`.
- Arrival: `inflight` is 1, so `fifo_data_out` is written to the next free slot.
- Pop rule (combinational): `fifo_pop = !fifo_empty && !flush && (occ + inflight - drain) < 2`, where `occ` is 0, 1 or 2 for EMPTY, ONE, TWO.
- FSM transitions:
  - EMPTY: arrival goes to ONE.
  - ONE: arrival with no drain goes to TWO; drain with no arrival goes to EMPTY; both, or neither, stays in ONE.
  - TWO: drain goes to ONE. Arrival without drain cannot occur by the pop rule and is flagged as an assertion failure.
- Ordering:
  - `buf1` shifts into `buf0` on drain.
  - Arrival writes `buf0` when the head is free after drain, otherwise `buf1`.
  - Words leave in exactly FIFO order.
- `m_valid` = (state != EMPTY). `m_data` = `buf0`.
- `m_data` must hold stable while `m_valid && !m_ready`.
- Flush:
  - Next state is EMPTY and `inflight` clears.
  - A word arriving in the flush cycle, or the cycle after it, is discarded.
  - `fifo_pop` is 0 during flush.
- Reset (asynchronous, `rd_rst` = 0):
  - State EMPTY, `inflight` 0.
  - `fifo_pop`, `m_valid` and `m_data` all 0.
  - Stats counters 0.
  - A pop issued before reset is lost by design; the FIFO is reset together with this block.

## Timing
- Pop-to-data latency: 1 cycle.
- First-word latency, from `fifo_empty` falling with the buffer EMPTY:
  - `fifo_pop` is high in the same cycle.
  - `m_valid` rises at the next edge plus one, i.e. 2 edges after `fifo_empty` is sampled low.
- Steady state with `m_ready` held at 1 and the FIFO non-empty: one word per cycle, `fifo_pop` continuously high.
- Back-pressure: after `m_ready` falls, at most 2 words are held; `fifo_pop` falls no later than the cycle the second word is in flight.
- Simultaneous drain and arrival in state ONE keeps the state at ONE with the new head loaded.
- `fifo_pop` depends combinationally on `m_ready`, `fifo_empty`, `flush` and state. All other outputs are registered.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `stat_words` increments on every `drain`.
  - `stat_stalls` increments on every cycle with `m_valid && !m_ready`.
  - Both counters saturate at 16'hFFFF and clear on reset only; flush does not clear them.
- Not defined:
  - Both counter ports are tied to 0.
  - No counter registers are synthesized.

## Test plan
1. **Single word.** Reset, then FIFO holds one word 8'hA5 and `m_ready` is held at 1.
   - `fifo_pop` pulses exactly once.
   - `m_valid` is high for 1 cycle with `m_data` = 8'hA5.
   - `stat_words` = 1.
2. **Streaming.** 16 words 0..15 pushed, `m_ready` held at 1.
   - 16 consecutive `m_valid` cycles with no gap after the first, data 0..15 in order.
   - `fifo_pop` never high while `fifo_empty` = 1.
3. **Back-pressure.** Same 16 words with `m_ready` low for cycles 3..12.
   - `m_data` stable while stalled.
   - No more than 2 pops outstanding beyond the last accepted word.
   - All 16 words received in order.
   - `stat_stalls` = 10.
4. **Flush.** Flush asserted with state TWO and one word in flight.
   - Next cycle `m_valid` = 0 and `fifo_pop` = 0 during flush.
   - Subsequent words resume from the FIFO's next entry; the discarded words never appear on `m_data`.
5. **Reset mid-stream.** `rd_rst` pulled low asynchronously mid-stream.
   - `m_valid`, `fifo_pop`, `m_data` and the counters go to 0 immediately, without waiting for a clock edge.
   - After release, operation restarts from EMPTY.
6. **Underflow guard.** FIFO empties while `m_ready` toggles randomly for 1000 cycles.
   - Zero instances of `fifo_pop && fifo_empty`.
   - Output sequence equals the input sequence.
